// File: rtl/mantle_slice_pack.sv
`default_nettype none
// ============================================================================
// Module      : mantle_slice_pack
// Description : Reassembles a WIDTH-bit word from SLICE-bit slices arriving
//               on a valid/ready stream. Optionally un-swaps the halves of
//               slice 0. Registered output with backpressure. A start-of-word
//               flag resynchronises the assembly.
// Revision    : 1.0 - initial release
// ============================================================================
module mantle_slice_pack #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4,
    parameter int SWAP0 = 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SLICE-1:0] in_data,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             resync_err
);

    localparam int c_nsl = WIDTH / SLICE;
    localparam int c_cw  = (c_nsl > 1) ? $clog2(c_nsl) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_nsl - 1);

    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_resync_err;

    logic             w_accept;
    logic             w_resync;
    logic [c_cw-1:0]  w_k;
    logic [c_cw-1:0]  w_cnt_next;
    logic             w_is_last;
    logic [SLICE-1:0] w_slice0;
    logic [SLICE-1:0] w_slice;
    logic [WIDTH-1:0] w_acc_next;

    // The final slice may only be taken once the output register is free.
    assign in_ready = (r_cnt != c_last) || !r_out_valid || out_ready;

    assign w_accept   = in_valid && in_ready;
    // A start-of-word flag mid-word abandons the partial word.
    assign w_resync   = in_first && (r_cnt != '0);
    assign w_k        = in_first ? '0 : r_cnt;
    assign w_is_last  = (w_k == c_last);
    assign w_cnt_next = w_is_last ? '0 : (w_k + 1'b1);

    // Slice 0 optionally arrives with its two halves exchanged.
    generate
        if (SWAP0 != 0) begin : g_swap
            assign w_slice0 = {in_data[SLICE/2-1:0], in_data[SLICE-1:SLICE/2]};
        end else begin : g_noswap
            assign w_slice0 = in_data;
        end
    endgenerate

    assign w_slice = (w_k == '0) ? w_slice0 : in_data;

    // Merge the incoming slice into the accumulator; slice 0 starts a fresh word.
    always_comb begin
        w_acc_next = (w_k == '0) ? '0 : r_acc;
        w_acc_next[SLICE*int'(w_k) +: SLICE] = w_slice;
    end

    // Slice counter, accumulator and resync pulse.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_resync_err <= 1'b0;
        end else begin
            r_resync_err <= w_accept && w_resync;
            if (w_accept) begin
                r_cnt <= w_cnt_next;
                r_acc <= w_acc_next;
            end
        end
    end

    // Output holding register: a new load wins over a same-cycle delivery.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept && w_is_last) begin
                r_out_data  <= w_acc_next;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign resync_err = r_resync_err;

endmodule
`default_nettype wire

// File: tb/tb_mantle_slice_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_mantle_slice_pack
// Description : Self-checking bench for mantle_slice_pack. Words driven are
//               pushed to a scoreboard queue and compared on delivery.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mantle_slice_pack;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid, in_ready, in_first;
    logic [3:0]  in_data;
    logic        out_valid, out_ready, resync_err;
    logic [15:0] out_data;

    logic        b_in_valid, b_in_ready, b_in_first;
    logic [3:0]  b_in_data;
    logic        b_out_valid, b_out_ready, b_resync_err;
    logic [7:0]  b_out_data;

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_stall = 0;
    int          n_deliv = 0;
    int          n_pulse = 0;
    int          cyc     = 0;
    logic [15:0] sb_q[$];

    mantle_slice_pack #(.WIDTH(16), .SLICE(4), .SWAP0(1)) u_dut (
        .clk(clk), .arst(arst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .resync_err(resync_err)
    );

    mantle_slice_pack #(.WIDTH(8), .SLICE(4), .SWAP0(0)) u_dut8 (
        .clk(clk), .arst(arst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_first(b_in_first),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .resync_err(b_resync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [3:0] sw(input logic [3:0] x);
        return {x[1:0], x[3:2]};
    endfunction

    // Scoreboard: compare each delivered word against the oldest expected one.
    always @(negedge clk) begin
        if (!arst && resync_err) n_pulse <= n_pulse + 1;
        if (!arst && out_valid && out_ready) begin
            n_deliv <= n_deliv + 1;
            if (sb_q.size() == 0) check("unexpected_word", 32'(out_data), 32'hDEAD_BEEF);
            else check("word", 32'(out_data), 32'(sb_q.pop_front()));
        end
    end

    // Present one slice, called at posedge+1; returns at posedge+1 after accept.
    task automatic send_slice(input logic [3:0] d, input logic first);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_first = first;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
            n_stall++;
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w);
        sb_q.push_back(w);
        for (int k = 0; k < 4; k++)
            send_slice((k == 0) ? sw(w[3:0]) : w[4*k +: 4], k == 0);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, c0, d0;
        arst = 1'b1;
        in_valid = 1'b0; in_first = 1'b0; in_data = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_first = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_resync", 32'(resync_err), 32'd0);
        arst = 1'b0;
        idle(1);

        // Basic pack: 7,C,B,A -> 0xABCD with no stalls.
        s0 = n_stall;
        send_word(16'hABCD);
        in_valid = 1'b0;
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data", 32'(out_data), 32'hABCD);
        check("basic_stalls", 32'(n_stall - s0), 32'd0);
        idle(1);
        check("basic_drained", 32'(out_valid), 32'd0);

        // Backpressure: held 0x1234 blocks the last slice of 0xA98D.
        out_ready = 1'b0;
        send_word(16'h1234);
        in_valid = 1'b0;
        check("bp_valid", 32'(out_valid), 32'd1);
        sb_q.push_back(16'hA98D);
        send_slice(4'h7, 1'b1);
        send_slice(4'h8, 1'b0);
        send_slice(4'h9, 1'b0);
        in_data = 4'hA; in_first = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(out_data), 32'h1234);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_nogap_valid", 32'(out_valid), 32'd1);
        check("bp_nogap_data", 32'(out_data), 32'hA98D);
        idle(2);

        // Resync: 5,6 discarded, F restarts, result 0xCDEF.
        sb_q.push_back(16'hCDEF);
        send_slice(4'h5, 1'b1);
        send_slice(4'h6, 1'b0);
        check("resync_quiet", 32'(resync_err), 32'd0);
        send_slice(4'hF, 1'b1);
        check("resync_pulse", 32'(resync_err), 32'd1);
        send_slice(4'hE, 1'b0);
        check("resync_pulse_end", 32'(resync_err), 32'd0);
        send_slice(4'hD, 1'b0);
        send_slice(4'hC, 1'b0);
        in_valid = 1'b0;
        check("resync_data", 32'(out_data), 32'hCDEF);
        idle(2);

        // Streaming: 3 words, 12 slices in 12 cycles.
        s0 = n_stall; c0 = cyc; d0 = n_deliv;
        send_word(16'h0F1E); check("stream_v1", 32'(out_valid), 32'd1);
        send_word(16'h9C3B); check("stream_v2", 32'(out_valid), 32'd1);
        send_word(16'hFFFF); check("stream_v3", 32'(out_valid), 32'd1);
        check("stream_cycles", 32'(cyc - c0), 32'd12);
        check("stream_stalls", 32'(n_stall - s0), 32'd0);
        idle(2);
        check("stream_delivered", 32'(n_deliv - d0), 32'd3);

        // Async reset with a held word and a 2-slice partial.
        out_ready = 1'b0;
        send_word(16'h7777);
        send_slice(4'h1, 1'b1);
        send_slice(4'h2, 1'b0);
        in_valid = 1'b0;
        #3;
        arst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_cnt", 32'(u_dut.r_cnt), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk); #1;
        arst = 1'b0;
        out_ready = 1'b1;
        send_word(16'h5A3C);
        in_valid = 1'b0;
        check("arst_resync", 32'(resync_err), 32'd0);
        check("arst_clean", 32'(out_data), 32'h5A3C);
        idle(2);

        // WIDTH=8, SWAP0=0 instance: 3, A -> 0xA3.
        b_in_valid = 1'b1; b_in_first = 1'b1; b_in_data = 4'h3;
        @(posedge clk); #1;
        b_in_first = 1'b0; b_in_data = 4'hA;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("w8_valid", 32'(b_out_valid), 32'd1);
        check("w8_data", 32'(b_out_data), 32'hA3);
        @(posedge clk); #1;
        check("w8_drained", 32'(b_out_valid), 32'd0);
        check("w8_resync", 32'(b_resync_err), 32'd0);

        idle(3);
        check("resync_pulse_total", 32'(n_pulse), 32'd1);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mantle_slice_pack.md
Name: mantle_slice_pack

Overview:
Reassembles a WIDTH-bit word from SLICE-bit slices that arrive serially over a valid/ready stream. It is the receive-side counterpart of the slice/concat wiring that splits a 16-bit bus into nibble fields, with the low field's half-swap. It sits between a narrow slice stream and a full-width consumer, and undoes the slice-0 half-swap when SWAP0=1. It has a registered output with backpressure, and it resynchronises on a start-of-word flag.

Parameters:
WIDTH, 16, assembled word width; must be a multiple of SLICE.
SLICE, 4, slice width; must be even when SWAP0=1.
SWAP0, 1, 1 = slice 0 arrives with its halves exchanged and is un-swapped on capture; 0 = no swap.

Ports:
clk  in  1  clock; all state updates on rising edge.
arst  in  1  asynchronous, active-high reset.
in_valid  in  1  slice present on in_data.
in_ready  out  1  block accepts a slice this cycle.
in_data  in  SLICE  slice payload.
in_first  in  1  slice is slice 0 of a new word; qualified by in_valid.
out_valid  out  1  assembled word held on out_data.
out_ready  in  1  consumer accepts the word.
out_data  out  WIDTH  assembled word.
resync_err  out  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- NSL = WIDTH/SLICE. Internal state:
  - slice counter cnt, range 0..NSL-1;
  - accumulator acc[WIDTH-1:0];
  - output register plus out_valid flag.
- Reset (arst high, asynchronous): cnt=0, acc=0, out_valid=0, out_data=0, resync_err=0. in_ready=1 during and after reset.
- Transfer rules:
  - A slice is accepted when in_valid && in_ready.
  - A word is delivered when out_valid && out_ready.
- Slice placement: slice k (k = cnt at acceptance) is written to acc[SLICE*k +: SLICE].
- SWAP0=1 and k=0: the stored value is {in_data[SLICE/2-1:0], in_data[SLICE-1:SLICE/2]}. Slices 1..NSL-1 are stored unmodified.
- Counting:
  - cnt increments on each accepted slice.
  - On the accepted slice with cnt=NSL-1, cnt wraps to 0.
  - On that same slice, the full word (acc with the final slice merged) is loaded into out_data and out_valid is set next cycle.
  - Latency: last slice accepted in cycle t -> out_valid=1 in cycle t+1.
- in_ready:
  - cnt != NSL-1: in_ready = 1.
  - cnt == NSL-1: in_ready = !out_valid || out_ready.
  - The block never overwrites an undelivered word.
- out_valid:
  - Cleared on delivery, unless a new word loads in the same cycle; load wins and out_valid stays 1.
  - Once set, out_data is stable until delivered.
- Resync:
  - An accepted slice with in_first=1 while cnt!=0 discards the partial acc and is stored as slice 0 (swap rules apply). cnt becomes 1.
  - resync_err pulses high for exactly one cycle (the cycle after acceptance).
  - in_first=1 at cnt=0: normal, no pulse.
  - in_first=0 at cnt=0: accepted as slice 0, no error.
- NSL=1 (WIDTH=SLICE): every accepted slice is a full word; in_ready follows the cnt==NSL-1 rule.
- Unused acc bits are never exposed; out_data only updates on word load.
- Reset mid-word or mid-hold: partial word and held word are both dropped; no resync_err pulse.
- Throughput: one slice per cycle sustained when the consumer holds out_ready=1. No bubble at word boundaries.

Test Plan:
- Basic pack, defaults:
  - Stimulus: slices 0x7, 0xC, 0xB, 0xA on consecutive cycles, first flag on 0x7, out_ready=1.
  - Response: out_valid=1 one cycle after 0xA with out_data=0xABCD; in_ready stays 1 throughout.
- Backpressure:
  - Stimulus: pack 0x1234 (slices 0x1, 0x3, 0x2, 0x1), out_ready=0; then send 0x7, 0x8, 0x9, 0xA.
  - Response: in_ready drops to 0 while cnt=3 with word held. out_data holds 0x1234 until out_ready=1. Then 0xA is accepted the same cycle and 0xA98D follows with no gap.
- Resync:
  - Stimulus: 0x5, 0x6, then 0xF with in_first=1, then 0xE, 0xD, 0xC.
  - Response: resync_err pulses once after 0xF is accepted; the 0x5/0x6 partial is discarded; out_data=0xCDEF.
- Streaming:
  - Stimulus: 3 back-to-back words with in_valid=1 and out_ready=1 continuously.
  - Response: 12 slices in 12 cycles; out_valid high on cycles 4, 8 and 12 after start; words are correct.
- Async reset:
  - Stimulus: assert arst mid-cycle after 2 slices and with a word held.
  - Response: out_valid=0, out_data=0, cnt=0 immediately (no clk edge needed). The next 4 slices form a clean word.
- SWAP0=0, WIDTH=8:
  - Stimulus: slices 0x3, 0xA.
  - Response: out_data=0xA3.
